// File: rtl/obc1_pkg.sv
// Shared constants, FSM state type and RMW merge helper for the OBC1 coprocessor.
package obc1_pkg;

    localparam int unsigned OBC1_OFS_W = 13;

    localparam logic [OBC1_OFS_W-1:0] OBC1_REG_LO   = 13'h1FF0;
    localparam logic [OBC1_OFS_W-1:0] OBC1_REG_HI   = 13'h1FF4;
    localparam logic [OBC1_OFS_W-1:0] OBC1_REG_BASE = 13'h1FF5;
    localparam logic [OBC1_OFS_W-1:0] OBC1_REG_IDX  = 13'h1FF6;

    localparam logic [OBC1_OFS_W-1:0] OBC1_BASE_1   = 13'h1800;
    localparam logic [OBC1_OFS_W-1:0] OBC1_BASE_0   = 13'h1C00;
    localparam logic [OBC1_OFS_W-1:0] OBC1_HI_OFS   = 13'h0200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_OUT,
        ST_RMW_RD,
        ST_RMW_WR
    } obc1_state_e;

    // Replace the 2-bit field at 'shift' in 'old' with 'bits'.
    function automatic logic [7:0] obc1_merge(input logic [7:0] old,
                                              input logic [1:0] bits,
                                              input logic [2:0] shift);
        logic [7:0] mask;
        mask = 8'(8'h03 << shift);
        return (old & ~mask) | 8'(8'(bits) << shift);
    endfunction

endpackage

// File: rtl/obc1_ram.sv
// Single-port synchronous attribute RAM, one-cycle read latency, write-first.
module obc1_ram #(
    parameter int unsigned AW = 13
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/obc1_core.sv
// OBC1 object-attribute coprocessor: register window remapped into attribute RAM
// through a base/index pair, with a 2-bit read-modify-write port at 0x1FF4.
module obc1_core
    import obc1_pkg::*;
#(
    parameter int unsigned RAM_AW = 13
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        obc1_enable,
    input  logic [12:0] SNES_ADDR,
    input  logic [7:0]  SNES_DATA_IN,
    input  logic        rd_strobe,
    input  logic        wr_strobe,
    output logic [7:0]  obc1_data_out,
    output logic        rd_valid,
    output logic        busy
);

    obc1_state_e     state, next_state;
    logic            base_sel;
    logic [6:0]      index;
    logic [12:0]     addr_q;
    logic [1:0]      bits_q;
    logic [2:0]      shift_q;

    logic [12:0]     base, lo_addr, hi_addr, dec_addr;
    logic            rd_go, wr_go;
    logic            ram_we;
    logic [12:0]     ram_addr;
    logic [7:0]      ram_wdata, ram_rdata;

    // Window decode from the shadow registers as they stand at strobe time.
    always_comb begin
        base    = base_sel ? OBC1_BASE_1 : OBC1_BASE_0;
        lo_addr = base + 13'({index, 2'b00}) + 13'(SNES_ADDR[1:0]);
        hi_addr = base + OBC1_HI_OFS + 13'(index[6:2]);
        if (SNES_ADDR[12:2] == OBC1_REG_LO[12:2]) begin
            dec_addr = lo_addr;
        end else if (SNES_ADDR == OBC1_REG_HI) begin
            dec_addr = hi_addr;
        end else begin
            dec_addr = SNES_ADDR;
        end
        wr_go = obc1_enable & wr_strobe;
        rd_go = obc1_enable & rd_strobe & ~wr_strobe;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        ram_wdata  = SNES_DATA_IN;
        case (state)
            ST_IDLE: begin
                ram_addr = dec_addr;
                if (wr_go) begin
                    if (SNES_ADDR == OBC1_REG_HI) begin
                        next_state = ST_RMW_RD;
                    end else begin
                        ram_we = 1'b1;
                    end
                end else if (rd_go) begin
                    next_state = ST_RD;
                end
            end
            ST_RD:     next_state = ST_RD_OUT;
            ST_RD_OUT: next_state = ST_IDLE;
            ST_RMW_RD: next_state = ST_RMW_WR;
            ST_RMW_WR: begin
                ram_we     = 1'b1;
                ram_wdata  = obc1_merge(ram_rdata, bits_q, shift_q);
                next_state = ST_IDLE;
            end
            default:   next_state = ST_IDLE;
        endcase
        if (RST) begin
            ram_we = 1'b0;
        end
    end

    // Shadow registers, strobe-time capture and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            base_sel      <= 1'b0;
            index         <= 7'h00;
            addr_q        <= 13'h0000;
            bits_q        <= 2'b00;
            shift_q       <= 3'b000;
            obc1_data_out <= 8'h00;
            rd_valid      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rd_valid <= (next_state == ST_RD_OUT);
            busy     <= (next_state != ST_IDLE);
            if (state == ST_RD) begin
                obc1_data_out <= ram_rdata;
            end
            if (state == ST_IDLE) begin
                addr_q  <= dec_addr;
                bits_q  <= SNES_DATA_IN[1:0];
                shift_q <= {index[1:0], 1'b0};
                if (wr_go && SNES_ADDR == OBC1_REG_BASE) begin
                    base_sel <= SNES_DATA_IN[0];
                end
                if (wr_go && SNES_ADDR == OBC1_REG_IDX) begin
                    index <= SNES_DATA_IN[6:0];
                end
            end
        end
    end

    obc1_ram #(
        .AW(RAM_AW)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .addr  (RAM_AW'(ram_addr)),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
